// File: rtl/reg_file_cmp.sv
`default_nettype none
// ============================================================================
// reg_file_cmp : 2**D x W register file with a dual-target write port, two read
//                ports, an accumulator tap on register 0, and an iterative
//                minimum-|ri-rj| scan engine. Optional macro: WRITE_BYPASS_EN.
// Revision    : 1.0
// ============================================================================
module reg_file_cmp #(
    parameter int W        = 8,
    parameter int D        = 3,
    parameter int CMP_BASE = 4,
    parameter int NCMP     = 3
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         AccRead,
    input  logic [1:0]   RegWrite,
    input  logic [D-1:0] ReadReg1,
    input  logic [D-1:0] ReadReg2,
    input  logic [W-1:0] WriteValue,
    output logic [W-1:0] ReadData1,
    output logic [W-1:0] ReadData2,
    output logic [W-1:0] Accumulator,
    input  logic         CmpStart,
    output logic         CmpBusy,
    output logic         CmpDone,
    output logic [W-1:0] CmpMin,
    output logic [D-1:0] CmpIdxA,
    output logic [D-1:0] CmpIdxB,
    output logic         CmpStale
);

    localparam int           NREG     = 2**D;
    localparam logic [D-1:0] WIN_FIRST = D'(CMP_BASE);
    localparam logic [D-1:0] WIN_SECOND = D'(CMP_BASE + 1);
    localparam logic [D-1:0] WIN_PENULT = D'(CMP_BASE + NCMP - 2);
    localparam logic [D-1:0] WIN_LAST  = D'(CMP_BASE + NCMP - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nxt;

    logic [W-1:0] regs [NREG];

    logic         we1;
    logic         we2;
    logic [W-1:0] rd1;
    logic [W-1:0] rd2;
    logic [W-1:0] acc;

    logic [D-1:0] scan_i;
    logic [D-1:0] scan_j;
    logic [W-1:0] run_min;
    logic [D-1:0] run_a;
    logic [D-1:0] run_b;

    logic [W-1:0] val_i;
    logic [W-1:0] val_j;
    logic [W-1:0] diff;
    logic         better;
    logic [W-1:0] min_nxt;
    logic [D-1:0] a_nxt;
    logic [D-1:0] b_nxt;
    logic         last_pair;
    logic         win_write;

    assign we1 = RegWrite[0];
    assign we2 = RegWrite[1];

    // ------------------------------------------------------------------
    // Register storage. A double write to one address carries the same
    // value on both targets, so it collapses to a single write.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int k = 0; k < NREG; k++) begin
                regs[k] <= '0;
            end
        end else begin
            if (we1) begin
                regs[ReadReg1] <= WriteValue;
            end
            if (we2) begin
                regs[ReadReg2] <= WriteValue;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
`ifdef WRITE_BYPASS_EN
    logic hit_r1;
    logic hit_r2;
    logic hit_r0;

    assign hit_r1 = we1 || (we2 && (ReadReg2 == ReadReg1));
    assign hit_r2 = we2 || (we1 && (ReadReg1 == ReadReg2));
    assign hit_r0 = (we1 && (ReadReg1 == '0)) || (we2 && (ReadReg2 == '0));
`endif

    always_comb begin
        rd1 = regs[ReadReg1];
        rd2 = regs[ReadReg2];
        acc = regs[0];
`ifdef WRITE_BYPASS_EN
        if (hit_r1) begin
            rd1 = WriteValue;
        end
        if (hit_r2) begin
            rd2 = WriteValue;
        end
        if (hit_r0) begin
            acc = WriteValue;
        end
`endif
    end

    assign ReadData1   = rd1;
    assign ReadData2   = AccRead ? acc : rd2;
    assign Accumulator = acc;

    // ------------------------------------------------------------------
    // Compare engine: one pair per cycle on live register contents
    // ------------------------------------------------------------------
    assign val_i     = regs[scan_i];
    assign val_j     = regs[scan_j];
    assign diff      = (val_i >= val_j) ? (val_i - val_j) : (val_j - val_i);
    assign better    = (diff < run_min);
    assign min_nxt   = better ? diff   : run_min;
    assign a_nxt     = better ? scan_i : run_a;
    assign b_nxt     = better ? scan_j : run_b;
    assign last_pair = (scan_i == WIN_PENULT) && (scan_j == WIN_LAST);

    assign win_write = (we1 && (ReadReg1 >= WIN_FIRST) && (ReadReg1 <= WIN_LAST)) ||
                       (we2 && (ReadReg2 >= WIN_FIRST) && (ReadReg2 <= WIN_LAST));

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (CmpStart)  state_nxt = SCAN;
            SCAN:    if (last_pair) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign CmpBusy = (state == SCAN);
    assign CmpDone = (state == DONE);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            scan_i   <= '0;
            scan_j   <= '0;
            run_min  <= '0;
            run_a    <= '0;
            run_b    <= '0;
            CmpMin   <= '0;
            CmpIdxA  <= '0;
            CmpIdxB  <= '0;
            CmpStale <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (CmpStart) begin
                        scan_i   <= WIN_FIRST;
                        scan_j   <= WIN_SECOND;
                        run_min  <= '1;
                        run_a    <= WIN_FIRST;
                        run_b    <= WIN_SECOND;
                        CmpStale <= 1'b0;
                    end
                end
                SCAN: begin
                    run_min <= min_nxt;
                    run_a   <= a_nxt;
                    run_b   <= b_nxt;
                    if (win_write) begin
                        CmpStale <= 1'b1;
                    end
                    // Results publish only on the edge that enters DONE.
                    if (last_pair) begin
                        CmpMin  <= min_nxt;
                        CmpIdxA <= a_nxt;
                        CmpIdxB <= b_nxt;
                    end else if (scan_j == WIN_LAST) begin
                        scan_i <= scan_i + D'(1);
                        scan_j <= scan_i + D'(2);
                    end else begin
                        scan_j <= scan_j + D'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
